// File: rtl/mtr_drv_nch.sv
// N-channel battery-compensated motor driver: scaled, saturated speed -> complementary dead-time PWM.
// Optional duty slew limiter enabled by defining MTR_SLEW_LIMIT_EN.
module mtr_drv_nch #(
  parameter int unsigned     NCH       = 2,
  parameter int unsigned     W         = 12,
  parameter int unsigned     SCALE_W   = 13,
  parameter int unsigned     FRAC      = 11,
  parameter int unsigned     DEAD      = 0,
  parameter logic [NCH-1:0]  INV_MASK  = 'b01,
  parameter int unsigned     SLEW_STEP = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH*W-1:0]   spd,
  input  logic [SCALE_W-1:0] scale,
  output logic [NCH-1:0]     PWM1,
  output logic [NCH-1:0]     PWM2,
  output logic [NCH-1:0]     sat,
  output logic               period_strt
);

  localparam int unsigned PW = W + SCALE_W;
  localparam logic [W-1:0] MID     = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W:0]   DEAD_W1 = (W+1)'(DEAD);
  localparam logic signed [PW-1:0] QMAX = PW'((1 << (W-1)) - 1);
  localparam logic signed [PW-1:0] QMIN = ~QMAX;
`ifdef MTR_SLEW_LIMIT_EN
  localparam logic [W:0]   STEP    = (W+1)'(SLEW_STEP);
`endif

  logic [W-1:0]              cnt;
  logic [NCH*W-1:0]          spd_s1;
  logic signed [SCALE_W-1:0] scale_s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      period_strt <= 1'b0;
      spd_s1      <= '0;
      scale_s1    <= '0;
    end else begin
      cnt         <= cnt + 1'b1;
      period_strt <= (cnt == CNT_MAX);
      spd_s1      <= spd;
      scale_s1    <= scale;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic signed [W-1:0]  spd_ch;
    logic signed [PW-1:0] prod_d, prod_q, q_shift, q;
    logic [W-1:0]         q_sat, tgt_d, tgt_q, duty_q, duty_nxt;
    logic                 sat_d, sat_q;
    logic                 pwm1_d, pwm2_d, pwm1_q, pwm2_q;

    assign spd_ch  = spd_s1[i*W +: W];
    assign prod_d  = PW'(spd_ch) * PW'(scale_s1);
    assign q_shift = prod_q >>> FRAC;
    // Negation happens at full product width so the most-negative speed saturates instead of wrapping.
    assign q       = INV_MASK[i] ? -q_shift : q_shift;

    always_comb begin
      sat_d = 1'b0;
      q_sat = q[W-1:0];
      if (q > QMAX) begin
        q_sat = QMAX[W-1:0];
        sat_d = 1'b1;
      end else if (q < QMIN) begin
        q_sat = QMIN[W-1:0];
        sat_d = 1'b1;
      end
      tgt_d = MID + q_sat;
    end

`ifdef MTR_SLEW_LIMIT_EN
    logic [W:0] diff;
    logic       up;

    always_comb begin
      up   = tgt_q > duty_q;
      diff = up ? ({1'b0, tgt_q} - {1'b0, duty_q}) : ({1'b0, duty_q} - {1'b0, tgt_q});
      if (diff <= STEP) begin
        duty_nxt = tgt_q;
      end else if (up) begin
        duty_nxt = W'({1'b0, duty_q} + STEP);
      end else begin
        duty_nxt = W'({1'b0, duty_q} - STEP);
      end
    end
`else
    assign duty_nxt = tgt_q;
`endif

    // cnt + 1 > DEAD is cnt >= DEAD without a constant compare when DEAD is 0.
    assign pwm1_d = (({1'b0, cnt} + (W+1)'(1)) > DEAD_W1) && (cnt < duty_q);
    assign pwm2_d = ({1'b0, cnt} >= ({1'b0, duty_q} + DEAD_W1));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prod_q <= '0;
        tgt_q  <= MID;
        sat_q  <= 1'b0;
        duty_q <= MID;
        pwm1_q <= 1'b0;
        pwm2_q <= 1'b0;
      end else begin
        prod_q <= prod_d;
        tgt_q  <= tgt_d;
        sat_q  <= sat_d;
        if (cnt == CNT_MAX) begin
          duty_q <= duty_nxt;
        end
        pwm1_q <= pwm1_d;
        pwm2_q <= pwm2_d;
      end
    end

    assign PWM1[i] = pwm1_q;
    assign PWM2[i] = pwm2_q;
    assign sat[i]  = sat_q;
  end

endmodule

// File: tb/tb_mtr_drv_nch.sv
// Self-checking bench for mtr_drv_nch: per-period PWM width scoreboard plus load-timing and reset sequences.
module tb_mtr_drv_nch;

  localparam int NCH = 2;
  localparam int W = 12;
  localparam int SCALE_W = 13;
  localparam int DEAD = 16;
  localparam int PERIOD = 4096;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH*W-1:0]     spd;
  logic [SCALE_W-1:0]   scale;
  logic [NCH-1:0]       pwm1, pwm2, sat;
  logic                 period_strt;

  mtr_drv_nch #(
    .NCH(NCH), .W(W), .SCALE_W(SCALE_W), .FRAC(11), .DEAD(DEAD),
    .INV_MASK(2'b01), .SLEW_STEP(256)
  ) dut (
    .clk(clk), .rst(rst), .spd(spd), .scale(scale),
    .PWM1(pwm1), .PWM2(pwm2), .sat(sat), .period_strt(period_strt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]       spd0;
    logic [W-1:0]       spd1;
    logic [SCALE_W-1:0] scale;
    logic [W-1:0]       duty0;
    logic [W-1:0]       duty1;
    logic [1:0]         sat;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[8];
  vec_t zv, va, vb, vmid;
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pw1_width(input int d);
    return (d > DEAD) ? d - DEAD : 0;
  endfunction

  function automatic int pw2_width(input int d);
    return (d + DEAD >= PERIOD) ? 0 : PERIOD - d - DEAD;
  endfunction

  // Called on the negedge of a cnt=0 cycle. Drives drv (optionally switching to mid_drv halfway),
  // measures the period just started and checks it against the oldest scoreboard entry.
  task automatic run_period(input vec_t drv, input bit mid, input vec_t mid_drv);
    vec_t fin, e;
    int h1[NCH], h2[NCH];
    int ps, ovl;
    spd   = {drv.spd1, drv.spd0};
    scale = drv.scale;
    fin   = mid ? mid_drv : drv;
    sb.push_back(fin);
    ps  = 0;
    ovl = 0;
    for (int c = 0; c < NCH; c++) begin
      h1[c] = 0;
      h2[c] = 0;
    end
    for (int j = 1; j <= PERIOD; j++) begin
      @(negedge clk);
      if (mid && j == 2000) begin
        spd   = {mid_drv.spd1, mid_drv.spd0};
        scale = mid_drv.scale;
      end
      for (int c = 0; c < NCH; c++) begin
        h1[c] += int'(pwm1[c]);
        h2[c] += int'(pwm2[c]);
      end
      if ((pwm1 & pwm2) != '0) ovl++;
      if (period_strt) ps++;
    end
    check("period_strt_at_wrap", int'(period_strt), 1);
    check("period_strt_pulses", ps, 1);
    check("pwm_overlap", ovl, 0);
    if (sb.size() < 2) begin
      check("scoreboard_depth", sb.size(), 2);
    end else begin
      e = sb.pop_front();
      check("pwm1_width_ch0", h1[0], pw1_width(int'(e.duty0)));
      check("pwm2_width_ch0", h2[0], pw2_width(int'(e.duty0)));
      check("pwm1_width_ch1", h1[1], pw1_width(int'(e.duty1)));
      check("pwm2_width_ch1", h2[1], pw2_width(int'(e.duty1)));
    end
    check("sat", int'(sat), int'(fin.sat));
  endtask

  initial begin
    //          spd0     spd1     scale     duty0    duty1    sat
    tbl[0] = '{12'h400, 12'h400, 13'h0800, 12'h400, 12'hC00, 2'b00};
    tbl[1] = '{12'h000, 12'h7FF, 13'h0FFF, 12'h800, 12'hFFF, 2'b10};
    tbl[2] = '{12'h000, 12'h800, 13'h0FFF, 12'h800, 12'h000, 2'b10};
    tbl[3] = '{12'h800, 12'h000, 13'h0800, 12'hFFF, 12'h800, 2'b01};
    tbl[4] = '{12'h7FF, 12'h123, 13'h0800, 12'h001, 12'h923, 2'b00};
    tbl[5] = '{12'h100, 12'h100, 13'h1000, 12'hA00, 12'h600, 2'b00};
    tbl[6] = '{12'hFFF, 12'hFFF, 13'h0400, 12'h801, 12'h7FF, 2'b00};
    tbl[7] = '{12'h000, 12'h000, 13'h0800, 12'h800, 12'h800, 2'b00};
    zv   = tbl[7];
    va   = tbl[0];
    vb   = '{12'h000, 12'h200, 13'h0800, 12'h800, 12'hA00, 2'b00};
    vmid = zv;

    rst   = 1'b1;
    spd   = '0;
    scale = 13'h0800;
    repeat (3) @(negedge clk);
    check("reset_pwm1", int'(pwm1), 0);
    check("reset_pwm2", int'(pwm2), 0);
    check("reset_sat", int'(sat), 0);
    check("reset_period_strt", int'(period_strt), 0);
    rst = 1'b0;

    // First measured period runs on the reset duty (midpoint).
    sb.push_back(vmid);
    for (int i = 0; i < 8; i++) begin
      run_period(tbl[i], 1'b0, tbl[i]);
    end

    // Target changes mid-period: current widths keep the old duty, only the value at wrap is loaded.
    run_period(va, 1'b1, vb);
    run_period(vb, 1'b0, vb);

    // Asynchronous reset while PWM1 is high on both channels.
    for (int j = 1; j <= 1000; j++) @(negedge clk);
    check("pre_reset_pwm1", int'(pwm1), 3);
    #1 rst = 1'b1;
    #1;
    check("async_reset_pwm1", int'(pwm1), 0);
    check("async_reset_pwm2", int'(pwm2), 0);
    check("async_reset_period_strt", int'(period_strt), 0);
    repeat (3) @(negedge clk);
    spd   = {va.spd1, va.spd0};
    scale = va.scale;
    rst   = 1'b0;
    sb.delete();
    sb.push_back(vmid);
    run_period(va, 1'b0, va);
    run_period(zv, 1'b0, zv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
